// File: rtl/kd_tree_node_p_if.sv
// Command+data link between a KD-tree node and one neighbour.
// master drives the request half (parent side), slave drives the response half (child side).
interface kd_tree_node_p_if #(
  parameter int DIM    = 3,
  parameter int DATA_W = 8
);
  logic [3:0]            req_cmd;
  logic [DIM*DATA_W-1:0] req_data;
  logic [3:0]            rsp_cmd;
  logic [DIM*DATA_W-1:0] rsp_data;

  modport master (output req_cmd, req_data, input  rsp_cmd, rsp_data);
  modport slave  (input  req_cmd, req_data, output rsp_cmd, rsp_data);
endinterface

// File: rtl/kd_tree_node_p.sv
// KD-tree node: subtree fill, per-level axis config, recursive compare-swap sort.
// Optional KD_NODE_STATS_EN adds a saturating swap_count output.
module kd_tree_node_p #(
  parameter int DIM    = 3,
  parameter int DATA_W = 8,
  parameter int AXIS_W = 2,
  parameter int LEAF   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  kd_tree_node_p_if.slave       top,
  kd_tree_node_p_if.master      left,
  kd_tree_node_p_if.master      right,
  output logic [DIM*DATA_W-1:0] self_center,
  output logic                  center_valid,
  output logic [AXIS_W-1:0]     sort_axis
`ifdef KD_NODE_STATS_EN
  , output logic [15:0]         swap_count
`endif
);
  localparam int W = DIM*DATA_W;
  localparam logic [3:0] NOP = 4'd0, FILL = 4'd1, FILL_ACK = 4'd2, AXIS = 4'd3, AXIS_DONE = 4'd4,
                         SORT = 4'd5, SORT_DONE = 4'd6, GET = 4'd7, CENTER = 4'd8, PUT = 4'd9,
                         PUT_ACK = 4'd10;

  typedef enum logic [3:0] {
    S_IDLE, S_FILL_L, S_FILL_R, S_AXIS, S_WAIT_L, S_CMP_L, S_PUT_L,
    S_WAIT_R, S_CMP_R, S_PUT_R, S_SORT_L, S_SORT_R
  } state_t;

  state_t            state, state_n;
  logic [3:0]        top_cmd, top_cmd_n, l_cmd, l_cmd_n, r_cmd, r_cmd_n;
  logic [W-1:0]      top_data, top_data_n, l_data, l_data_n, r_data, r_data_n;
  logic [W-1:0]      center, center_n, peer, peer_n;
  logic              valid, valid_n, lfull, lfull_n, rfull, rfull_n;
  logic              got_l, got_l_n, got_r, got_r_n, changed, changed_n;
  logic [AXIS_W-1:0] axis, axis_n, eff, axis_next;

  function automatic logic [DATA_W-1:0] coord(input logic [W-1:0] v, input logic [AXIS_W-1:0] a);
    return v[a*DATA_W +: DATA_W];
  endfunction

  // Out-of-range axis compares on coordinate 0.
  assign eff       = (32'(axis) >= DIM) ? '0 : axis;
  assign axis_next = AXIS_W'((32'(top.req_data[AXIS_W-1:0]) + 32'd1) % DIM);

  always_comb begin
    state_n    = state;
    top_cmd_n  = NOP;  top_data_n = '0;
    l_cmd_n    = NOP;  l_data_n   = '0;
    r_cmd_n    = NOP;  r_data_n   = '0;
    center_n   = center;  valid_n = valid;  axis_n = axis;
    lfull_n    = lfull;   rfull_n = rfull;
    got_l_n    = got_l;   got_r_n = got_r;
    peer_n     = peer;    changed_n = changed;
    case (state)
      S_IDLE: begin
        case (top.req_cmd)
          FILL: begin
            if (LEAF != 0 || (lfull && rfull)) begin
              if (!valid) begin center_n = top.req_data; valid_n = 1'b1; end
              top_cmd_n = FILL_ACK;  top_data_n[0] = 1'b1;
            end else if (!lfull) begin
              l_cmd_n = FILL;  l_data_n = top.req_data;  state_n = S_FILL_L;
            end else begin
              r_cmd_n = FILL;  r_data_n = top.req_data;  state_n = S_FILL_R;
            end
          end
          AXIS: begin
            axis_n = top.req_data[AXIS_W-1:0];
            if (LEAF != 0) top_cmd_n = AXIS_DONE;
            else begin
              l_cmd_n = AXIS;  l_data_n[AXIS_W-1:0] = axis_next;
              r_cmd_n = AXIS;  r_data_n[AXIS_W-1:0] = axis_next;
              got_l_n = 1'b0;  got_r_n = 1'b0;  state_n = S_AXIS;
            end
          end
          GET: begin top_cmd_n = CENTER;  top_data_n = center; end
          PUT: begin center_n = top.req_data;  top_cmd_n = PUT_ACK; end
          SORT: begin
            if (!valid || LEAF != 0) top_cmd_n = SORT_DONE;
            else begin l_cmd_n = GET;  changed_n = 1'b0;  state_n = S_WAIT_L; end
          end
          default: ;
        endcase
      end
      S_FILL_L: if (left.rsp_cmd == FILL_ACK) begin
        lfull_n = left.rsp_data[0];
        top_cmd_n = FILL_ACK;  top_data_n[0] = left.rsp_data[0] & rfull & valid;
        state_n = S_IDLE;
      end
      S_FILL_R: if (right.rsp_cmd == FILL_ACK) begin
        rfull_n = right.rsp_data[0];
        top_cmd_n = FILL_ACK;  top_data_n[0] = right.rsp_data[0] & lfull & valid;
        state_n = S_IDLE;
      end
      S_AXIS: begin
        // Children may finish in either order or together.
        got_l_n = got_l | (left.rsp_cmd == AXIS_DONE);
        got_r_n = got_r | (right.rsp_cmd == AXIS_DONE);
        if (got_l_n && got_r_n) begin top_cmd_n = AXIS_DONE;  state_n = S_IDLE; end
      end
      S_WAIT_L: if (left.rsp_cmd == CENTER) begin peer_n = left.rsp_data;  state_n = S_CMP_L; end
      S_CMP_L: begin
        if (coord(peer, eff) > coord(center, eff)) begin
          l_cmd_n = PUT;  l_data_n = center;  state_n = S_PUT_L;
        end else begin r_cmd_n = GET;  state_n = S_WAIT_R; end
      end
      S_PUT_L: if (left.rsp_cmd == PUT_ACK) begin
        center_n = peer;  changed_n = 1'b1;  r_cmd_n = GET;  state_n = S_WAIT_R;
      end
      S_WAIT_R: if (right.rsp_cmd == CENTER) begin peer_n = right.rsp_data;  state_n = S_CMP_R; end
      S_CMP_R: begin
        if (coord(peer, eff) < coord(center, eff)) begin
          r_cmd_n = PUT;  r_data_n = center;  state_n = S_PUT_R;
        end else begin l_cmd_n = SORT;  state_n = S_SORT_L; end
      end
      S_PUT_R: if (right.rsp_cmd == PUT_ACK) begin
        center_n = peer;  changed_n = 1'b1;  l_cmd_n = SORT;  state_n = S_SORT_L;
      end
      S_SORT_L: if (left.rsp_cmd == SORT_DONE) begin
        changed_n = changed | left.rsp_data[0];  r_cmd_n = SORT;  state_n = S_SORT_R;
      end
      S_SORT_R: if (right.rsp_cmd == SORT_DONE) begin
        top_cmd_n = SORT_DONE;  top_data_n[0] = changed | right.rsp_data[0];  state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      top_cmd <= NOP;  top_data <= '0;  l_cmd <= NOP;  l_data <= '0;  r_cmd <= NOP;  r_data <= '0;
      center <= '0;  valid <= 1'b0;  axis <= '0;  lfull <= 1'b0;  rfull <= 1'b0;
      got_l <= 1'b0;  got_r <= 1'b0;  peer <= '0;  changed <= 1'b0;
    end else begin
      state <= state_n;
      top_cmd <= top_cmd_n;  top_data <= top_data_n;
      l_cmd <= l_cmd_n;  l_data <= l_data_n;  r_cmd <= r_cmd_n;  r_data <= r_data_n;
      center <= center_n;  valid <= valid_n;  axis <= axis_n;  lfull <= lfull_n;  rfull <= rfull_n;
      got_l <= got_l_n;  got_r <= got_r_n;  peer <= peer_n;  changed <= changed_n;
    end
  end

`ifdef KD_NODE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) swap_count <= '0;
    else if (((state == S_PUT_L && left.rsp_cmd == PUT_ACK) ||
              (state == S_PUT_R && right.rsp_cmd == PUT_ACK)) && swap_count != 16'hFFFF)
      swap_count <= swap_count + 16'd1;
  end
`endif

  assign top.rsp_cmd    = top_cmd;
  assign top.rsp_data   = top_data;
  assign left.req_cmd   = (LEAF != 0) ? NOP : l_cmd;
  assign left.req_data  = (LEAF != 0) ? '0  : l_data;
  assign right.req_cmd  = (LEAF != 0) ? NOP : r_cmd;
  assign right.req_data = (LEAF != 0) ? '0  : r_data;
  assign self_center    = center;
  assign center_valid   = valid;
  assign sort_axis      = axis;
endmodule
